control_fsm: RTL

CONTROL_FSM -- requirements
Module: control_fsm

---
 rtl/cpu_pkg.sv | 101 ++++++++++
 rtl/imm_gen.sv | 40 ++++
 rtl/control_fsm.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the control FSM: opcodes, extended opcodes,
// FSM state codes and the instruction classification helper.
package cpu_pkg;

    // Primary opcodes (IR[15:12]); these are also the ALU opcode values
    localparam logic [3:0] OP_RTYPE  = 4'b0000;
    localparam logic [3:0] OP_ANDI   = 4'b0001;
    localparam logic [3:0] OP_LWI    = 4'b0011;
    localparam logic [3:0] OP_MEM    = 4'b0100;
    localparam logic [3:0] OP_ADDI   = 4'b0101;
    localparam logic [3:0] OP_ADDUI  = 4'b0110;
    localparam logic [3:0] OP_ADDCI  = 4'b0111;
    localparam logic [3:0] OP_SHIFT  = 4'b1000;
    localparam logic [3:0] OP_SUBI   = 4'b1001;
    localparam logic [3:0] OP_CMPI   = 4'b1011;
    localparam logic [3:0] OP_ADDCUI = 4'b1101;

    // Extended opcodes (IR[7:4])
    localparam logic [3:0] EX_NOP  = 4'b0000;
    localparam logic [3:0] EX_LW   = 4'b0000;
    localparam logic [3:0] EX_SW   = 4'b0100;
    localparam logic [3:0] EX_RSHI = 4'b0111;
    localparam logic [3:0] EX_LSHI = 4'b1000;
    localparam logic [3:0] EX_CMPU = 4'b1000;
    localparam logic [3:0] EX_CMP  = 4'b1011;

    // FSM state encodings
    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;

    // Per-instruction control bits captured in DECODE
    typedef struct packed {
        logic illegal;
        logic psr_upd;
        logic wr_en;
        logic is_mem;
        logic is_sw;
        logic is_lw;
    } dec_t;

    // Classify an instruction word; anything not recognised is illegal
    function automatic dec_t decode_ir(input logic [15:0] ir);
        dec_t d;
        logic [3:0] op;
        logic [3:0] ex;
        op = ir[15:12];
        ex = ir[7:4];
        d.illegal = 1'b0;
        d.psr_upd = 1'b0;
        d.wr_en   = 1'b0;
        d.is_mem  = 1'b0;
        d.is_sw   = 1'b0;
        d.is_lw   = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (ex)
                    EX_NOP: d.illegal = 1'b0;
                    4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0110,
                    4'b0111, 4'b1001, 4'b1010: begin
                        d.psr_upd = 1'b1;
                        d.wr_en   = 1'b1;
                    end
                    EX_CMPU, EX_CMP: d.psr_upd = 1'b1;
                    default: d.illegal = 1'b1;
                endcase
            end
            OP_ANDI, OP_ADDI, OP_ADDUI, OP_ADDCI, OP_SUBI, OP_ADDCUI: begin
                d.psr_upd = 1'b1;
                d.wr_en   = 1'b1;
            end
            OP_CMPI: d.psr_upd = 1'b1;
            OP_LWI:  d.wr_en   = 1'b1;
            OP_MEM: begin
                case (ex)
                    EX_LW: begin
                        d.is_mem = 1'b1;
                        d.is_lw  = 1'b1;
                        d.wr_en  = 1'b1;
                    end
                    EX_SW: begin
                        d.is_mem = 1'b1;
                        d.is_sw  = 1'b1;
                    end
                    default: d.illegal = 1'b1;
                endcase
            end
            OP_SHIFT: begin
                case (ex)
                    EX_LSHI, EX_RSHI: d.wr_en = 1'b1;
                    default: d.illegal = 1'b1;
                endcase
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: selects and extends the immediate field of IR.
// use_imm tells the FSM whether alu_b takes the immediate or Rsrc data.
module imm_gen
    import cpu_pkg::*;
(
    input  logic [15:0] ir,
    output logic [15:0] imm,
    output logic        use_imm
);

    // Pick sign-extended imm8, zero-extended imm8 or a shift amount
    always_comb begin
        imm     = 16'h0000;
        use_imm = 1'b0;
        case (ir[15:12])
            OP_ADDI, OP_ADDCI, OP_SUBI, OP_CMPI: begin
                imm     = {{8{ir[7]}}, ir[7:0]};
                use_imm = 1'b1;
            end
            OP_ADDUI, OP_ADDCUI, OP_ANDI, OP_LWI: begin
                imm     = {8'h00, ir[7:0]};
                use_imm = 1'b1;
            end
            OP_SHIFT: begin
                if ((ir[7:4] == EX_LSHI) || (ir[7:4] == EX_RSHI)) begin
                    imm     = {12'h000, ir[3:0]};
                    use_imm = 1'b1;
                end else begin
                    imm     = 16'h0000;
                    use_imm = 1'b0;
                end
            end
            default: begin
                imm     = 16'h0000;
                use_imm = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle CPU control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> WB.
// All outputs are registered; rf_ra/rf_rb and alu_cin are wired straight
// from registers (IR, psr) so they carry no combinational logic.
module control_fsm
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          PSR_W    = 5
) (
    input  logic             clk,
    input  logic             reset,
    output logic             mem_req,
    output logic             mem_we,
    output logic [15:0]      mem_addr,
    output logic [15:0]      mem_wdata,
    input  logic [15:0]      mem_rdata,
    input  logic             mem_ack,
    output logic [3:0]       rf_ra,
    output logic [3:0]       rf_rb,
    input  logic [15:0]      rf_a_data,
    input  logic [15:0]      rf_b_data,
    output logic             rf_we,
    output logic [3:0]       rf_wa,
    output logic [15:0]      rf_wdata,
    output logic [3:0]       alu_op,
    output logic [3:0]       alu_exop,
    output logic [15:0]      alu_a,
    output logic [15:0]      alu_b,
    output logic             alu_cin,
    input  logic [15:0]      alu_out,
    input  logic [PSR_W-1:0] alu_flags,
    output logic [PSR_W-1:0] psr,
    output logic [15:0]      pc,
    output logic             illegal
);

    logic [2:0]  state_r;
    logic [15:0] ir_r;
    dec_t        dec_r;
    dec_t        dec_s;
    logic [15:0] imm_s;
    logic        use_imm_s;

    imm_gen u_imm_gen (
        .ir      (ir_r),
        .imm     (imm_s),
        .use_imm (use_imm_s)
    );

    assign dec_s   = decode_ir(ir_r);
    assign rf_ra   = ir_r[11:8];
    assign rf_rb   = ir_r[3:0];
    assign alu_cin = psr[0];

    // State sequencing and all registered outputs. alu_a/alu_b double as
    // the latched store data and memory address for LW/SW, and rf_wdata
    // doubles as the result register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_FETCH;
            ir_r      <= 16'h0000;
            dec_r     <= '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            pc        <= RESET_PC;
            psr       <= {PSR_W{1'b0}};
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 16'h0000;
            rf_we     <= 1'b0;
            rf_wa     <= 4'h0;
            rf_wdata  <= 16'h0000;
            alu_op    <= 4'h0;
            alu_exop  <= 4'h0;
            alu_a     <= 16'h0000;
            alu_b     <= 16'h0000;
            illegal   <= 1'b0;
        end else begin
            rf_we   <= 1'b0;
            illegal <= 1'b0;
            case (state_r)
                ST_FETCH: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= pc;
                    end else if (mem_ack) begin
                        ir_r    <= mem_rdata;
                        mem_req <= 1'b0;
                        state_r <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    alu_a    <= rf_a_data;
                    alu_b    <= use_imm_s ? imm_s : rf_b_data;
                    alu_op   <= ir_r[15:12];
                    alu_exop <= ir_r[7:4];
                    dec_r    <= dec_s;
                    illegal  <= dec_s.illegal;
                    state_r  <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (dec_r.psr_upd) begin
                        psr <= alu_flags;
                    end
                    rf_wa <= ir_r[11:8];
                    if (dec_r.is_mem) begin
                        mem_req   <= 1'b1;
                        mem_we    <= dec_r.is_sw;
                        mem_addr  <= alu_b;
                        mem_wdata <= alu_a;
                        state_r   <= ST_MEM;
                    end else begin
                        rf_wdata <= alu_out;
                        rf_we    <= dec_r.wr_en;
                        state_r  <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wdata <= 16'h0000;
                        if (dec_r.is_lw) begin
                            rf_wdata <= mem_rdata;
                        end
                        rf_we   <= dec_r.wr_en;
                        state_r <= ST_WB;
                    end
                end
                ST_WB: begin
                    pc       <= pc + 16'd1;
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= pc + 16'd1;
                    state_r  <= ST_FETCH;
                end
                default: begin
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    state_r <= ST_FETCH;
                end
            endcase
        end
    end

endmodule
